// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider: registered divided-clock level plus
// a one-cycle tick per output period, with ratio changes deferred to period boundaries.
module clk_divider_prog #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             out_clk,
  output logic             tick,
  output logic [DIV_W-1:0] cur_div,
  output logic             upd_pending,
  output logic             ratio_err
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

  logic [DIV_W-1:0] cnt_q,  cnt_d;
  logic [DIV_W-1:0] div_q,  div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             out_clk_q, out_clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic [DIV_W-1:0] high_cnt;
  logic [DIV_W-1:0] apply_val;
  logic             wrap;
  logic             apply_edge;
  logic             do_apply;

  // High phase is ceil(N/2) so odd ratios carry the extra cycle high.
  assign high_cnt   = (div_q >> 1) + DIV_W'(div_q[0]);
  assign wrap       = (cnt_q == div_q - DIV_W'(1));
  assign apply_edge = !en || wrap;
  // A load landing on the apply edge bypasses the pending register.
  assign apply_val  = div_load ? div_val : pend_q;
  assign do_apply   = apply_edge && (div_load || pend_vld_q);

  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    out_clk_d  = 1'b0;
    tick_d     = 1'b0;
    err_d      = err_q;

    if (en) begin
      out_clk_d = (cnt_q < high_cnt);
      tick_d    = (cnt_q == '0);
      cnt_d     = wrap ? '0 : cnt_q + DIV_W'(1);
    end else begin
      cnt_d = '0;
    end

    if (do_apply) begin
      pend_vld_d = 1'b0;
      if (apply_val < MIN_DIV) begin
        div_d = MIN_DIV;
        err_d = 1'b1;
      end else begin
        div_d = apply_val;
        err_d = 1'b0;
      end
    end else if (div_load) begin
      pend_d     = div_val;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      div_q      <= RST_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      out_clk_q  <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      out_clk_q  <= out_clk_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end

  assign out_clk     = out_clk_q;
  assign tick        = tick_q;
  assign cur_div     = div_q;
  assign upd_pending = pend_vld_q;
  assign ratio_err   = err_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed self-checking bench for clk_divider_prog with hand-computed waveforms.
module tb_clk_divider_prog;

  localparam int unsigned DIV_W = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] div_val;
  logic             div_load;
  logic             out_clk;
  logic             tick;
  logic [DIV_W-1:0] cur_div;
  logic             upd_pending;
  logic             ratio_err;

  int n_cmp;
  int n_err;

  clk_divider_prog #(.DIV_W(DIV_W), .DEFAULT_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .div_val     (div_val),
    .div_load    (div_load),
    .out_clk     (out_clk),
    .tick        (tick),
    .cur_div     (cur_div),
    .upd_pending (upd_pending),
    .ratio_err   (ratio_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic edge_chk(input string tag, input logic eo, input logic et);
    step();
    chk({tag, ".out"}, 32'(out_clk), 32'(eo));
    chk({tag, ".tick"}, 32'(tick), 32'(et));
  endtask

  // Checks whole periods starting at a period boundary; h is the hand-computed high count.
  task automatic wave(input string tag, input int n, input int h, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      edge_chk(tag, logic'((k % n) < h), logic'((k % n) == 0));
      chk({tag, ".div"}, 32'(cur_div), 32'(n));
      chk({tag, ".pend"}, 32'(upd_pending), 32'd0);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b0;
    en       = 1'b0;
    div_load = 1'b0;
    div_val  = '0;

    // Reset values
    #1 rst = 1'b1;
    #1;
    chk("rst.out", 32'(out_clk), 32'd0);
    chk("rst.tick", 32'(tick), 32'd0);
    chk("rst.div", 32'(cur_div), 32'd4);
    chk("rst.pend", 32'(upd_pending), 32'd0);
    chk("rst.err", 32'(ratio_err), 32'd0);
    step();
    rst = 1'b0;
    en  = 1'b1;

    // Default ratio 4: out 1,1,0,0 and tick on edges 1,5,9
    wave("def4", 4, 2, 12);

    // Disabled load of 5 applies directly
    en = 1'b0; div_load = 1'b1; div_val = 8'd5;
    step();
    chk("dis5.out", 32'(out_clk), 32'd0);
    chk("dis5.tick", 32'(tick), 32'd0);
    chk("dis5.div", 32'(cur_div), 32'd5);
    chk("dis5.pend", 32'(upd_pending), 32'd0);
    div_load = 1'b0; en = 1'b1;
    wave("run5", 5, 3, 10);

    // Running at 5, load 6 on the tick edge; period finishes at 5
    div_load = 1'b1; div_val = 8'd6;
    edge_chk("ld6.e0", 1'b1, 1'b1);
    chk("ld6.e0.pend", 32'(upd_pending), 32'd1);
    chk("ld6.e0.div", 32'(cur_div), 32'd5);
    div_load = 1'b0;
    edge_chk("ld6.e1", 1'b1, 1'b0);
    chk("ld6.e1.pend", 32'(upd_pending), 32'd1);
    edge_chk("ld6.e2", 1'b1, 1'b0);
    chk("ld6.e2.pend", 32'(upd_pending), 32'd1);
    edge_chk("ld6.e3", 1'b0, 1'b0);
    chk("ld6.e3.pend", 32'(upd_pending), 32'd1);
    chk("ld6.e3.div", 32'(cur_div), 32'd5);
    edge_chk("ld6.wrap", 1'b0, 1'b0);
    chk("ld6.wrap.pend", 32'(upd_pending), 32'd0);
    chk("ld6.wrap.div", 32'(cur_div), 32'd6);
    wave("run6", 6, 3, 12);

    // Illegal ratio 1 coerced to 2
    en = 1'b0; div_load = 1'b1; div_val = 8'd1;
    step();
    chk("ill.div", 32'(cur_div), 32'd2);
    chk("ill.err", 32'(ratio_err), 32'd1);
    chk("ill.out", 32'(out_clk), 32'd0);
    div_load = 1'b0; en = 1'b1;
    wave("run2", 2, 1, 6);
    chk("run2.err", 32'(ratio_err), 32'd1);

    // Load 3 while at 2: applied at the very next wrap, clears the error
    div_load = 1'b1; div_val = 8'd3;
    edge_chk("ld3.e0", 1'b1, 1'b1);
    chk("ld3.e0.pend", 32'(upd_pending), 32'd1);
    chk("ld3.e0.err", 32'(ratio_err), 32'd1);
    div_load = 1'b0;
    edge_chk("ld3.wrap", 1'b0, 1'b0);
    chk("ld3.wrap.div", 32'(cur_div), 32'd3);
    chk("ld3.wrap.err", 32'(ratio_err), 32'd0);
    chk("ld3.wrap.pend", 32'(upd_pending), 32'd0);
    wave("run3", 3, 2, 9);

    // Load coincident with the wrap edge applies directly
    edge_chk("co4.e0", 1'b1, 1'b1);
    edge_chk("co4.e1", 1'b1, 1'b0);
    div_load = 1'b1; div_val = 8'd4;
    edge_chk("co4.wrap", 1'b0, 1'b0);
    chk("co4.pend", 32'(upd_pending), 32'd0);
    chk("co4.div", 32'(cur_div), 32'd4);
    div_load = 1'b0;
    wave("run4", 4, 2, 8);

    // Drop en at cnt=2 of N=4 with 7 pending
    div_load = 1'b1; div_val = 8'd7;
    edge_chk("dr7.e0", 1'b1, 1'b1);
    div_load = 1'b0;
    edge_chk("dr7.e1", 1'b1, 1'b0);
    chk("dr7.e1.pend", 32'(upd_pending), 32'd1);
    en = 1'b0;
    edge_chk("dr7.off", 1'b0, 1'b0);
    chk("dr7.off.div", 32'(cur_div), 32'd7);
    chk("dr7.off.pend", 32'(upd_pending), 32'd0);
    en = 1'b1;
    wave("run7", 7, 4, 14);

    // Maximum ratio 255: high 128, low 127
    en = 1'b0; div_load = 1'b1; div_val = 8'd255;
    step();
    chk("max.div", 32'(cur_div), 32'd255);
    div_load = 1'b0; en = 1'b1;
    wave("run255", 255, 128, 512);

    // Running at 8 with 3 pending, async reset mid-high phase
    en = 1'b0; div_load = 1'b1; div_val = 8'd8;
    step();
    div_load = 1'b0; en = 1'b1;
    edge_chk("r8.e0", 1'b1, 1'b1);
    div_load = 1'b1; div_val = 8'd3;
    edge_chk("r8.e1", 1'b1, 1'b0);
    div_load = 1'b0;
    chk("r8.pend", 32'(upd_pending), 32'd1);
    chk("r8.div", 32'(cur_div), 32'd8);
    #3 rst = 1'b1;
    #1;
    chk("arst.out", 32'(out_clk), 32'd0);
    chk("arst.tick", 32'(tick), 32'd0);
    chk("arst.div", 32'(cur_div), 32'd4);
    chk("arst.pend", 32'(upd_pending), 32'd0);
    chk("arst.err", 32'(ratio_err), 32'd0);
    #2 rst = 1'b0;
    wave("post", 4, 2, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
